// File: rtl/mdu_pkg.sv
// rtl/mdu_pkg.sv - shared MD op encodings, widths and result type for the multiply/divide unit
package mdu_pkg;

   localparam int WORD = 32;

   localparam int DEF_MULT_CYCLES = 5;
   localparam int DEF_DIV_CYCLES  = 10;

   // E_MDOp encodings; 9-15 decode as no operation
   localparam logic [3:0] MD_NONE  = 4'd0;
   localparam logic [3:0] MD_MULT  = 4'd1;
   localparam logic [3:0] MD_MULTU = 4'd2;
   localparam logic [3:0] MD_DIV   = 4'd3;
   localparam logic [3:0] MD_DIVU  = 4'd4;
   localparam logic [3:0] MD_MTHI  = 4'd5;
   localparam logic [3:0] MD_MTLO  = 4'd6;
   localparam logic [3:0] MD_MFHI  = 4'd7;
   localparam logic [3:0] MD_MFLO  = 4'd8;

   typedef struct packed {
      logic [WORD-1:0] hi;
      logic [WORD-1:0] lo;
   } md_result_t;

endpackage

// File: rtl/mdu_core.sv
// rtl/mdu_core.sv - combinational multiply/divide datapath producing {hi, lo} for one MD op
module mdu_core
   import mdu_pkg::*;
(
   input  logic [3:0]      op,
   input  logic [WORD-1:0] a,
   input  logic [WORD-1:0] b,
   output md_result_t      res,
   output logic            div_by_zero
);

   logic [2*WORD-1:0] prod;
   logic [WORD-1:0]   dividend_mag;
   logic [WORD-1:0]   divisor_mag;
   logic [WORD-1:0]   quot_mag;
   logic [WORD-1:0]   rem_mag;
   logic              is_signed_div;

   // Signed division works on magnitudes so 0x80000000 / -1 needs no special case.
   always_comb begin
      prod          = '0;
      res           = '0;
      div_by_zero   = 1'b0;
      is_signed_div = (op == MD_DIV);
      dividend_mag  = (is_signed_div && a[WORD-1]) ? (~a + 1'b1) : a;
      divisor_mag   = (is_signed_div && b[WORD-1]) ? (~b + 1'b1) : b;
      // Substitute a divisor of 1 when b is zero; the result is discarded anyway
      if (divisor_mag == '0) begin
         divisor_mag = {{(WORD-1){1'b0}}, 1'b1};
      end
      quot_mag = dividend_mag / divisor_mag;
      rem_mag  = dividend_mag % divisor_mag;
      case (op)
         MD_MULT: begin
            prod = $signed({{WORD{a[WORD-1]}}, a}) * $signed({{WORD{b[WORD-1]}}, b});
            res  = prod;
         end
         MD_MULTU: begin
            prod = {{WORD{1'b0}}, a} * {{WORD{1'b0}}, b};
            res  = prod;
         end
         MD_DIV: begin
            div_by_zero = (b == '0);
            res.lo      = (a[WORD-1] ^ b[WORD-1]) ? (~quot_mag + 1'b1) : quot_mag;
            res.hi      = a[WORD-1] ? (~rem_mag + 1'b1) : rem_mag;
         end
         MD_DIVU: begin
            div_by_zero = (b == '0);
            res.lo      = quot_mag;
            res.hi      = rem_mag;
         end
         default: begin
            res = '0;
         end
      endcase
   end

endmodule

// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - E-stage multiply/divide unit with HI/LO registers and fixed-latency busy window
module mult_div_unit
   import mdu_pkg::*;
#(
   parameter int MULT_CYCLES = DEF_MULT_CYCLES,
   parameter int DIV_CYCLES  = DEF_DIV_CYCLES
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [3:0]  E_MDOp,
   input  logic [31:0] E_ALUA,
   input  logic [31:0] E_NextB,
   output logic        E_Start,
   output logic        E_Busy,
   output logic [31:0] E_MDOut,
   output logic [31:0] HI,
   output logic [31:0] LO
);

   localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CW         = $clog2(MAX_CYCLES + 1);

   logic [CW-1:0] counter;
   logic [CW-1:0] load_cycles;
   logic          busy_q;
   logic [31:0]   pend_hi;
   logic [31:0]   pend_lo;
   logic          pend_dz;
   logic          is_mul;
   logic          is_div;
   md_result_t    core_res;
   logic          core_dz;

   mdu_core u_core (
      .op          (E_MDOp),
      .a           (E_ALUA),
      .b           (E_NextB),
      .res         (core_res),
      .div_by_zero (core_dz)
   );

   assign is_mul      = (E_MDOp == MD_MULT) || (E_MDOp == MD_MULTU);
   assign is_div      = (E_MDOp == MD_DIV)  || (E_MDOp == MD_DIVU);
   assign E_Start     = (is_mul || is_div) && !busy_q;
   assign E_Busy      = busy_q;
   assign load_cycles = is_mul ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);

   // mfhi/mflo read the architectural registers directly, never pending or same-cycle writes
   always_comb begin
      E_MDOut = '0;
      if (E_MDOp == MD_MFHI) begin
         E_MDOut = HI;
      end else if (E_MDOp == MD_MFLO) begin
         E_MDOut = LO;
      end
   end

   // Busy counter, pending result capture, completion write-back and mthi/mtlo
   always_ff @(posedge clk) begin
      if (reset) begin
         counter <= '0;
         busy_q  <= 1'b0;
         pend_hi <= '0;
         pend_lo <= '0;
         pend_dz <= 1'b0;
         HI      <= '0;
         LO      <= '0;
      end else begin
         if (E_Start) begin
            pend_hi <= core_res.hi;
            pend_lo <= core_res.lo;
            pend_dz <= core_dz;
            counter <= load_cycles;
            busy_q  <= (load_cycles != '0);
         end else if (counter == CW'(1)) begin
            // A zero divisor keeps the busy window but leaves HI/LO untouched
            if (!pend_dz) begin
               HI <= pend_hi;
               LO <= pend_lo;
            end
            counter <= '0;
            busy_q  <= 1'b0;
         end else if (counter != '0) begin
            counter <= counter - CW'(1);
         end
         if (!busy_q && E_MDOp == MD_MTHI) begin
            HI <= E_ALUA;
         end
         if (!busy_q && E_MDOp == MD_MTLO) begin
            LO <= E_ALUA;
         end
      end
   end

`ifndef SYNTHESIS
   // The hazard unit must never issue an MD write or start into a busy unit
   always @(posedge clk) begin
      if (!reset && busy_q) begin
         assert (!(is_mul || is_div || E_MDOp == MD_MTHI || E_MDOp == MD_MTLO))
            else $warning("mult_div_unit: MD op %0d issued while busy, ignored", E_MDOp);
      end
   end
`endif

endmodule

// File: tb/tb_mult_div_unit.sv
// tb/tb_mult_div_unit.sv - directed self-checking bench for mult_div_unit
module tb_mult_div_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic [3:0]  E_MDOp;
   logic [31:0] E_ALUA;
   logic [31:0] E_NextB;
   logic        E_Start;
   logic        E_Busy;
   logic [31:0] E_MDOut;
   logic [31:0] HI;
   logic [31:0] LO;

   int tests_run = 0;
   int tests_failed = 0;

   mult_div_unit dut (
      .clk     (clk),
      .reset   (reset),
      .E_MDOp  (E_MDOp),
      .E_ALUA  (E_ALUA),
      .E_NextB (E_NextB),
      .E_Start (E_Start),
      .E_Busy  (E_Busy),
      .E_MDOut (E_MDOut),
      .HI      (HI),
      .LO      (LO)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Advance to just after the next rising edge; inputs set afterwards belong to the new cycle
   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   // Issue one mult/div, verify the busy window length and that HI/LO hold their old values
   task automatic md_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int n, input logic [31:0] old_hi, input logic [31:0] old_lo,
                        input string nm);
      E_MDOp = op; E_ALUA = a; E_NextB = b;
      #1;
      tests_run++;
      if (E_Start !== 1'b1 || E_Busy !== 1'b0) begin
         tests_failed++;
         $display("FAIL %s_start: E_Start=%b E_Busy=%b required 1/0", nm, E_Start, E_Busy);
      end
      tick();
      E_MDOp = 4'd0; E_ALUA = '0; E_NextB = '0;
      for (int i = 1; i <= n; i++) begin
         #1;
         tests_run++;
         if (E_Busy !== 1'b1 || HI !== old_hi || LO !== old_lo) begin
            tests_failed++;
            $display("FAIL %s_busy_c%0d: busy=%b HI=%h LO=%h required 1 %h %h",
                     nm, i, E_Busy, HI, LO, old_hi, old_lo);
         end
         tick();
      end
      #1;
      tests_run++;
      if (E_Busy !== 1'b0) begin
         tests_failed++;
         $display("FAIL %s_done: E_Busy=%b required 0", nm, E_Busy);
      end
   endtask

   task automatic check_hilo(input logic [31:0] eh, input logic [31:0] el, input string nm);
      tests_run++;
      if (HI !== eh || LO !== el) begin
         tests_failed++;
         $display("FAIL %s: HI=%h LO=%h required %h %h", nm, HI, LO, eh, el);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; E_MDOp = 4'd0; E_ALUA = '0; E_NextB = '0;
      tick();
      tick();
      reset = 1'b0;
      E_MDOp = 4'd7;
      #1;
      check_hilo(32'h0, 32'h0, "reset_hilo");
      tests_run++;
      if (E_Busy !== 1'b0 || E_MDOut !== 32'h0 || E_Start !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset_out: busy=%b mdout=%h start=%b required 0 0 0", E_Busy, E_MDOut, E_Start);
      end
      tick();
   endtask

   task automatic test_move();
      E_MDOp = 4'd5; E_ALUA = 32'h1234_5678;
      #1;
      tests_run++;
      if (E_Start !== 1'b0) begin
         tests_failed++;
         $display("FAIL mthi_start: E_Start=%b required 0", E_Start);
      end
      tick();
      E_MDOp = 4'd7; E_ALUA = '0;
      #1;
      tests_run++;
      if (E_MDOut !== 32'h1234_5678) begin
         tests_failed++;
         $display("FAIL mfhi: E_MDOut=%h required 12345678", E_MDOut);
      end
      E_MDOp = 4'd8;
      #1;
      tests_run++;
      if (E_MDOut !== 32'h0) begin
         tests_failed++;
         $display("FAIL mflo_zero: E_MDOut=%h required 00000000", E_MDOut);
      end
      tick();
   endtask

   task automatic test_mult();
      md_op(4'd1, 32'hFFFF_FFFE, 32'd3, 5, 32'h1234_5678, 32'h0, "mult");
      check_hilo(32'hFFFF_FFFF, 32'hFFFF_FFFA, "mult_result");
      E_MDOp = 4'd8;
      #1;
      tests_run++;
      if (E_MDOut !== 32'hFFFF_FFFA) begin
         tests_failed++;
         $display("FAIL mult_mflo: E_MDOut=%h required fffffffa", E_MDOut);
      end
      tick();
      md_op(4'd2, 32'hFFFF_FFFF, 32'd2, 5, 32'hFFFF_FFFF, 32'hFFFF_FFFA, "multu");
      check_hilo(32'h0000_0001, 32'hFFFF_FFFE, "multu_result");
      tick();
   endtask

   task automatic test_div();
      md_op(4'd3, 32'hFFFF_FFF9, 32'd2, 10, 32'h0000_0001, 32'hFFFF_FFFE, "div");
      check_hilo(32'hFFFF_FFFF, 32'hFFFF_FFFD, "div_result");
      tick();
      md_op(4'd4, 32'd7, 32'd2, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD, "divu");
      check_hilo(32'd1, 32'd3, "divu_result");
      tick();
   endtask

   task automatic test_div_edge();
      E_MDOp = 4'd5; E_ALUA = 32'hA;
      tick();
      E_MDOp = 4'd6; E_ALUA = 32'hB;
      tick();
      md_op(4'd3, 32'd5, 32'd0, 10, 32'hA, 32'hB, "div0");
      check_hilo(32'hA, 32'hB, "div0_unchanged");
      tick();
      md_op(4'd4, 32'd9, 32'd0, 10, 32'hA, 32'hB, "divu0");
      check_hilo(32'hA, 32'hB, "divu0_unchanged");
      tick();
      md_op(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'hA, 32'hB, "div_ovf");
      check_hilo(32'h0, 32'h8000_0000, "div_ovf_result");
      tick();
   endtask

   task automatic test_abort();
      E_MDOp = 4'd6; E_ALUA = 32'hC;
      tick();
      E_MDOp = 4'd1; E_ALUA = 32'd3; E_NextB = 32'd4;
      tick();
      E_MDOp = 4'd0; E_ALUA = '0; E_NextB = '0;
      tick();
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      #1;
      tests_run++;
      if (E_Busy !== 1'b0) begin
         tests_failed++;
         $display("FAIL abort_busy: E_Busy=%b required 0", E_Busy);
      end
      check_hilo(32'h0, 32'h0, "abort_hilo");
      for (int i = 0; i < 8; i++) tick();
      check_hilo(32'h0, 32'h0, "abort_no_late_write");
   endtask

   task automatic test_back_to_back();
      E_MDOp = 4'd6; E_ALUA = 32'h55;
      tick();
      E_MDOp = 4'd1; E_ALUA = 32'd2; E_NextB = 32'd5;
      tick();
      E_MDOp = 4'd3; E_ALUA = 32'd100; E_NextB = 32'd3;
      #1;
      tests_run++;
      if (E_Start !== 1'b0 || E_Busy !== 1'b1) begin
         tests_failed++;
         $display("FAIL busy_start: E_Start=%b E_Busy=%b required 0 1", E_Start, E_Busy);
      end
      tick();
      E_MDOp = 4'd5; E_ALUA = 32'h99;
      tick();
      E_MDOp = 4'd0; E_ALUA = '0; E_NextB = '0;
      check_hilo(32'h0, 32'h55, "busy_mthi_ignored");
      tick();
      tick();
      #1;
      tests_run++;
      if (E_Busy !== 1'b1) begin
         tests_failed++;
         $display("FAIL busy_last_cycle: E_Busy=%b required 1", E_Busy);
      end
      tick();
      #1;
      tests_run++;
      if (E_Busy !== 1'b0) begin
         tests_failed++;
         $display("FAIL busy_not_extended: E_Busy=%b required 0", E_Busy);
      end
      check_hilo(32'h0, 32'hA, "b2b_mult_result");
      E_MDOp = 4'd15; E_ALUA = 32'hDEAD_BEEF; E_NextB = 32'h1;
      #1;
      tests_run++;
      if (E_MDOut !== 32'h0 || E_Start !== 1'b0) begin
         tests_failed++;
         $display("FAIL invalid_op: mdout=%h start=%b required 0 0", E_MDOut, E_Start);
      end
      tick();
      E_MDOp = 4'd0;
      #1;
      check_hilo(32'h0, 32'hA, "invalid_op_no_write");
   endtask

   initial begin
      test_reset();
      test_move();
      test_mult();
      test_div();
      test_div_edge();
      test_abort();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- E-stage multiply/divide unit with architectural HI/LO registers.
- Consumes the forwarded E-stage operands (E_ALUA = rs, E_NextB = rt) from the operand-select muxes, alongside the ALU.
- Models fixed multi-cycle latency with a busy counter; the hazard unit uses E_Start/E_Busy to stall MD instructions in D.
- Drives E_MDOut (mfhi/mflo result) into the E-stage result path toward the M pipeline register.

Parameters:
- MULT_CYCLES, 5, busy cycles after a mult/multu start.
- DIV_CYCLES, 10, busy cycles after a div/divu start.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- E_MDOp  input  4  E-stage MD op: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 mfhi, 8 mflo; 9-15 treated as none.
- E_ALUA  input  32  forwarded rs value.
- E_NextB  input  32  forwarded rt value.
- E_Start  output  1  combinational; high when E_MDOp is 1-4 and the unit is not busy.
- E_Busy  output  1  registered; high while a mult/div is in flight.
- E_MDOut  output  32  combinational; HI when op 7, LO when op 8, else 0.
- HI  output  32  current HI register.
- LO  output  32  current LO register.

Behaviour:
- Reset (synchronous, active-high): HI=0, LO=0, counter=0, E_Busy=0, pending regs=0. A reset during a busy window aborts the operation; no HI/LO write occurs afterward.
- Start:
  - At the edge ending start cycle t, the result is computed from E_ALUA/E_NextB and latched into pend_hi/pend_lo.
  - counter loads MULT_CYCLES or DIV_CYCLES.
  - E_Busy = (counter != 0), registered.
  - E_Busy is high during cycles t+1 .. t+N.
- Completion:
  - At the edge ending cycle t+N (counter==1): HI<=pend_hi, LO<=pend_lo, counter<=0.
  - An mfhi/mflo in cycle t+N+1 sees the new values.
- Arithmetic:
  - mult: signed 32x32 -> 64-bit product; HI = upper word, LO = lower word.
  - multu: same, unsigned.
  - div: LO = quotient truncated toward zero; HI = remainder with the sign of the dividend.
  - divu: unsigned quotient and remainder.
  - div 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
  - Divisor 0 (div/divu): the busy window still runs; HI/LO are left unchanged at completion.
- mthi/mtlo: when not busy, HI (or LO) <= E_ALUA at the edge ending the cycle.
- mthi/mtlo/start while E_Busy=1:
  - The op is ignored.
  - A simulation-only assertion fires, since the hazard unit guarantees this cannot happen.
- mfhi/mflo:
  - Read the HI/LO register value combinationally.
  - No bypass of pending results.
  - No bypass of an mthi/mtlo in the same cycle.
- Stall contract, enforced by the hazard unit: any D-stage op 1-8 stalls while (E_Start | E_Busy). This module does not generate the stall itself.
- A pipeline flush does not cancel an in-flight operation; once started, it always completes.

Decomposition:
- Shared package mdu_pkg holds:
  - MD op encoding constants (MD_NONE .. MD_MFLO).
  - Default cycle counts.
  - A width constant WORD=32.
- Natural sub-module: mdu_core.
  - Purely combinational.
  - Takes op, a, b; returns {hi, lo} and a div_by_zero flag.
- The top level holds counter, pending regs, HI/LO, and control.

Test Plan:
- Reset, then op 7 -> E_MDOut=0. mthi 0x12345678, then mfhi -> E_MDOut=0x12345678.
- mult with a=0xFFFFFFFE (-2), b=3 -> E_Start=1 in cycle t; E_Busy=1 for exactly 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA. HI/LO stay at their old values until the t+5 edge.
- multu with a=0xFFFFFFFF, b=2 -> after 5 cycles HI=0x00000001, LO=0xFFFFFFFE.
- div with a=-7 (0xFFFFFFF9), b=2 -> after 10 busy cycles LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1). divu with 7/2 -> LO=3, HI=1.
- div by 0 with HI=0xA, LO=0xB preset -> E_Busy high 10 cycles; HI/LO unchanged. Then div 0x80000000 / -1 -> LO=0x80000000, HI=0.
- Reset asserted in cycle t+3 of a mult -> next cycle E_Busy=0, HI=LO=0, and no later HI/LO update. A start issued while busy is ignored and E_Start=0.
